gpio_input_filter: RTL
======================

Name: gpio_input_filter

Overview:
- Input-conditioning stage directly upstream of the GPIO controller and its interrupt output.
- Per pin it synchronises raw pad inputs into gpio_clk, debounces them with a programmable glitch filter, and detects rising/falling edges.
- Edges latch sticky per-pin pending bits; the OR of all pending bits forms the aggregate interrupt.
- Outputs give the controller clean read data (gpio_filtered), per-pin interrupt status (int_pending) and one level interrupt line (gpio_int).

Parameters:
GPIO_NUMS, `GPIO_NUMS, number of pins
CNT_W, 8, debounce counter / limit width

Ports:
gpio_clk  input  1  block clock
rst  input  1  asynchronous reset, active-low
gpio_in  input  GPIO_NUMS  raw asynchronous pad inputs
filter_en  input  GPIO_NUMS  per-pin debounce enable (1 = filtered)
debounce_limit  input  CNT_W  consecutive stable cycles required; 0 treated as 1
rise_en  input  GPIO_NUMS  per-pin rising-edge interrupt enable
fall_en  input  GPIO_NUMS  per-pin falling-edge interrupt enable
int_clear  input  1  single-cycle clear strobe
int_clear_mask  input  GPIO_NUMS  bits to clear when int_clear=1 (write-1-to-clear)
gpio_filtered  output  GPIO_NUMS  debounced pin state
int_pending  output  GPIO_NUMS  sticky per-pin edge flags
gpio_int  output  1  OR of int_pending

Behaviour:
- Interface: reset rst, asynchronous, active-low; clock gpio_clk. All state updates on posedge gpio_clk.
- Reset values: sync flops, stable, stable_d, counters, gpio_filtered, int_pending and gpio_int all 0.
- Synchroniser: two-flop chain per pin (s1 <= gpio_in; s2 <= s1). No logic between the two stages.
- Debounce, per pin, with L = max(debounce_limit, 1):
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt == L-1: stable <= s2, cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - filter_en=0 behaves exactly as L=1.
  - A toggle of filter_en resets that pin's cnt to 0 on the same edge.
  - A change of debounce_limit mid-count takes effect on the next comparison. The counter never exceeds L-1.
- Latency: a clean gpio_in change is reflected on gpio_filtered on the (2+L)th posedge after it is sampled. Unfiltered latency is 3.
- Glitch rejection: a pulse on s2 shorter than L cycles never changes stable and never sets a pending bit.
- gpio_filtered = stable (registered).
- Edge detect: stable_d <= stable.
  - rise[i] = stable & ~stable_d & rise_en.
  - fall[i] = ~stable & stable_d & fall_en.
  - Both enables set: either edge sets pending.
- Pending update: pending <= (pending & ~(int_clear ? int_clear_mask : 0)) | rise | fall.
  - A new edge in the same cycle as a clear of that bit: set wins, bit stays 1.
  - Clear with int_clear=0 has no effect.
  - Unmasked bits are untouched.
- int_pending timing: rises on the posedge after gpio_filtered changes.
- gpio_int: combinational OR of the registered pending flops, so it is glitch-free.
- Enables are not retroactive: clearing rise_en/fall_en does not clear existing pending bits, and setting them does not flag past edges.
- Pin high at reset release: stable is 0, so the first qualified high produces a rising edge. This is intended (power-on level report). Software clears it.
- Reset asserted mid-operation: all state returns to 0 immediately, asynchronously; in-flight counts are discarded.

Test Plan (GPIO_NUMS=8, CNT_W=8):
1. Unfiltered latency: filter_en=0, rise_en=8'h01, gpio_in[0] 0->1 before edge E -> gpio_filtered[0]=1 after E+2, int_pending=8'h01 after E+3, gpio_int=1.
2. Glitch reject: filter_en=8'h02, debounce_limit=4, fall_en=8'h02, gpio_in[1] high 3 cycles then low -> gpio_filtered[1] and int_pending[1] stay 0. Next, high for 4 cycles -> gpio_filtered[1]=1 exactly 6 posedges after sampling.
3. Both edges plus W1C: rise_en=fall_en=8'h04, pulse pin 2 high then low (clean) -> pending[2]=1. int_clear=1, mask=8'h04 -> pending=0, gpio_int=0. Mask 8'h08 instead -> pending[2] remains 1.
4. Clear/set collision: schedule int_clear with mask 8'h10 on the same edge pin 4's rising edge is detected -> int_pending[4]=1 afterwards.
5. debounce_limit=0 with filter_en=1 -> identical latency to scenario 1 (3 cycles).
6. Async reset: assert rst=0 mid-count with pending=8'hFF -> all outputs 0 without a clock edge. Release with gpio_in=8'h01, rise_en=8'h01 -> int_pending=8'h01 after 4 posedges.

Source files
------------

// File: rtl/gpio_input_filter.sv
// GPIO input conditioning: per-pin two-flop synchroniser, programmable debounce,
// edge detection into sticky write-1-to-clear pending flags and an aggregate interrupt.
`ifndef GPIO_NUMS
`define GPIO_NUMS 8
`endif

module gpio_input_filter #(
   parameter int GPIO_NUMS = `GPIO_NUMS,
   parameter int CNT_W     = 8
) (
   input  logic                 gpio_clk,
   input  logic                 rst,
   input  logic [GPIO_NUMS-1:0] gpio_in,
   input  logic [GPIO_NUMS-1:0] filter_en,
   input  logic [CNT_W-1:0]     debounce_limit,
   input  logic [GPIO_NUMS-1:0] rise_en,
   input  logic [GPIO_NUMS-1:0] fall_en,
   input  logic                 int_clear,
   input  logic [GPIO_NUMS-1:0] int_clear_mask,
   output logic [GPIO_NUMS-1:0] gpio_filtered,
   output logic [GPIO_NUMS-1:0] int_pending,
   output logic                 gpio_int
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   // Terminal count L-1; an unfiltered pin or a zero limit behaves as L = 1.
   function automatic logic [CNT_W-1:0] last_count(input logic [CNT_W-1:0] limit,
                                                   input logic             filt);
      if (!filt || limit == '0)
         return '0;
      return limit - CNT_ONE;
   endfunction

   logic [GPIO_NUMS-1:0] sync_s1;
   logic [GPIO_NUMS-1:0] sync_s2;
   logic [GPIO_NUMS-1:0] stable;
   logic [GPIO_NUMS-1:0] stable_d;
   logic [GPIO_NUMS-1:0] filter_en_d;
   logic [GPIO_NUMS-1:0] pending;
   logic [GPIO_NUMS-1:0] rise;
   logic [GPIO_NUMS-1:0] fall;
   logic [GPIO_NUMS-1:0] clr;
   logic [CNT_W-1:0]     cnt [GPIO_NUMS];

   // Stage 1-2: synchroniser chain, no logic between the flops
   always_ff @(posedge gpio_clk or negedge rst) begin
      if (!rst) begin
         sync_s1 <= '0;
         sync_s2 <= '0;
      end else begin
         sync_s1 <= gpio_in;
         sync_s2 <= sync_s1;
      end
   end

   // Stage 3: debounce; >= keeps the count bounded when the limit shrinks mid-count
   always_ff @(posedge gpio_clk or negedge rst) begin
      if (!rst) begin
         stable      <= '0;
         filter_en_d <= '0;
         for (int i = 0; i < GPIO_NUMS; i++)
            cnt[i] <= '0;
      end else begin
         filter_en_d <= filter_en;
         for (int i = 0; i < GPIO_NUMS; i++) begin
            if (sync_s2[i] != stable[i] &&
                cnt[i] >= last_count(debounce_limit, filter_en[i]))
               stable[i] <= sync_s2[i];
            if (sync_s2[i] == stable[i] ||
                cnt[i] >= last_count(debounce_limit, filter_en[i]) ||
                filter_en[i] != filter_en_d[i])
               cnt[i] <= '0;
            else
               cnt[i] <= cnt[i] + CNT_ONE;
         end
      end
   end

   assign rise = stable & ~stable_d & rise_en;
   assign fall = ~stable & stable_d & fall_en;
   assign clr  = int_clear ? int_clear_mask : '0;

   // Stage 4: edge history and sticky pending; a new edge wins over a clear
   always_ff @(posedge gpio_clk or negedge rst) begin
      if (!rst) begin
         stable_d <= '0;
         pending  <= '0;
      end else begin
         stable_d <= stable;
         pending  <= (pending & ~clr) | rise | fall;
      end
   end

   assign gpio_filtered = stable;
   assign int_pending   = pending;
   assign gpio_int      = |pending;

endmodule
